mult_booth: RTL and testbench

Multi-cycle signed 32x32 multiplier for the MIPS datapath, implementing the MULT instruction.
- Uses radix-2 Booth recoding: one add/sub plus arithmetic shift per clock, 32 iterations.
- Writes the 64-bit product to HI/LO and pulses a one-cycle completion flag.
- The control unit stalls on mult_start until mult_end; same start/end handshake as the division unit.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_booth_if.sv | 26 ++
 rtl/mult_booth_step.sv | 36 +++
 rtl/mult_booth.sv | 108 ++++++++++
 tb/tb_mult_booth.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the radix-2 Booth multiplier (MIPS MULT).
//   WIDTH  operand width; HI and LO are WIDTH bits each
//   ITER   Booth iterations, one per clock (equal to WIDTH)
//   CNT_W  iteration counter width
//   ADD/SUB  Booth codes for {q[0], q_1}
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = WIDTH;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mult_state_e;

endpackage

// File: rtl/mult_booth_if.sv
// Start/end handshake and operand/result bus between the control unit and the multiplier.
//   A, B        signed operands, sampled on the start edge
//   mult_start  start request (control unit stalls until mult_end)
//   mult_end    one-cycle completion pulse
//   HI, LO      product bits [63:32] and [31:0]
interface mult_booth_if;
  import mult_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mult_start;
  logic             mult_end;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output A, B, mult_start,
    input  mult_end, HI, LO
  );

  modport slave (
    input  A, B, mult_start,
    output mult_end, HI, LO
  );

endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into acc, followed by an
// arithmetic right shift of the 66-bit {acc, q, q_1} register. Purely combinational.
//   acc_i, q_i, q_1_i  current working register
//   m_i                sign-extended multiplicand (guard bit included)
//   acc_o, q_o, q_1_o  working register after this iteration
module mult_booth_step
  import mult_pkg::*;
(
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_i;
    unique case ({q_i[0], q_1_i})
      ADD:     sum = acc_i + m_i;
      SUB:     sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
  end

  // Arithmetic shift: the guard bit replicates into the new acc MSB.
  always_comb begin
    acc_o = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/mult_booth.sv
// Multi-cycle signed WIDTH x WIDTH multiplier (MIPS MULT), radix-2 Booth, one step per clock.
// A start edge in any state loads the operands and restarts; ITER edges later HI/LO are
// loaded and mult_end pulses for one cycle.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of the start/end handshake (A, B, mult_start, mult_end, HI, LO)
module mult_booth
  import mult_pkg::*;
(
  input logic        clock,
  input logic        reset,
  mult_booth_if.slave bus
);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_1_q, q_1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             end_q, end_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             step_q_1;

  mult_booth_step u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q_1_i (q_1_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q),
    .q_1_o (step_q_1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q_1_d   = q_1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    end_d   = 1'b0;

    // Start wins in every state, including an abort of a running operation.
    if (bus.mult_start) begin
      m_d     = {bus.A[WIDTH-1], bus.A};
      acc_d   = '0;
      q_d     = bus.B;
      q_1_d   = 1'b0;
      cnt_d   = CNT_W'(ITER);
      hi_d    = '0;
      lo_d    = '0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          acc_d = step_acc;
          q_d   = step_q;
          q_1_d = step_q_1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_d    = step_acc[WIDTH-1:0];
            lo_d    = step_q;
            end_d   = 1'b1;
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q_1_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q_1_q   <= q_1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      end_q   <= end_d;
    end
  end

  assign bus.mult_end = end_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: each start pushes the reference product and start cycle;
// every mult_end pops and checks HI, LO and the start-to-end latency.
module tb_mult_booth;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [63:0] prod;
    int          c0;
  } exp_t;

  exp_t exp_q[$];

  mult_booth_if bus ();

  mult_booth dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Call just after a negedge; holds mult_start for exactly one rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.prod = 64'(longint'($signed(a)) * longint'($signed(b)));
    e.c0   = cyc;
    exp_q.push_back(e);
    bus.A          = a;
    bus.B          = b;
    bus.mult_start = 1'b1;
    @(negedge clock);
    #1;
    bus.mult_start = 1'b0;
  endtask

  task automatic wait_done(input bit scramble);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
      if (scramble) begin
        bus.A = $urandom;
        bus.B = $urandom;
      end
    end
    if (exp_q.size() != 0) begin
      check_eq("timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Result monitor: end must only appear when an operation is outstanding.
  always @(negedge clock) begin
    exp_t e;
    if (bus.mult_end === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_end", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("hi", 64'(bus.HI), 64'(e.prod[63:32]));
        check_eq("lo", 64'(bus.LO), 64'(e.prod[31:0]));
        check_eq("latency", 64'(cyc - e.c0 - 1), 64'd32);
      end
    end
  end

  initial begin
    bus.A          = '0;
    bus.B          = '0;
    bus.mult_start = 1'b0;

    #12;
    check_eq("rst_hi", 64'(bus.HI), 64'd0);
    check_eq("rst_lo", 64'(bus.LO), 64'd0);
    check_eq("rst_end", 64'(bus.mult_end), 64'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;

    // Basic and boundary products.
    start_op(32'd3, 32'd5);
    wait_done(1'b0);
    start_op(32'hFFFFFFFF, 32'd1);
    wait_done(1'b0);
    start_op(32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0);
    start_op(32'h80000000, 32'h80000000);
    wait_done(1'b0);
    // Started in DONE: back-to-back with the previous completion.
    start_op(32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done(1'b0);
    repeat (3) @(negedge clock);
    #1;

    // Abort: restart at cycle 10 of the first operation; only the second may complete.
    start_op(32'd7, 32'd9);
    repeat (9) @(negedge clock);
    #1;
    exp_q.delete();
    start_op(32'hFFFFFFFC, 32'd6);
    wait_done(1'b0);
    repeat (2) @(negedge clock);
    #1;

    // Operands ignored while running, results hold while idle.
    start_op(32'd12, 32'hFFFFFFFD);
    wait_done(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("hold_hi", 64'(bus.HI), 64'h00000000FFFFFFFF);
      check_eq("hold_lo", 64'(bus.LO), 64'h00000000FFFFFFDC);
      check_eq("hold_end", 64'(bus.mult_end), 64'd0);
    end

    // Async reset while idle with nonzero HI/LO clears them before any edge.
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_idle_hi", 64'(bus.HI), 64'd0);
    check_eq("arst_idle_lo", 64'(bus.LO), 64'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    #1;

    // Async reset mid-operation; no end may follow until a new start.
    start_op(32'd100, 32'd200);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_eq("arst_run_hi", 64'(bus.HI), 64'd0);
    check_eq("arst_run_lo", 64'(bus.LO), 64'd0);
    check_eq("arst_run_end", 64'(bus.mult_end), 64'd0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (40) @(negedge clock);
    #1;

    // Random signed operands, back-to-back.
    for (int i = 0; i < 6; i++) begin
      start_op($urandom, $urandom);
      wait_done(1'b0);
    end
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
